// File: rtl/fsk_tx.sv
// M-ary phase-continuous FSK transmitter with a valid/ready symbol stream.
// Optional alternating 0,1 preamble before each burst: define FSK_TX_PREAMBLE_EN.
module fsk_tx #(
  parameter int p_acc_sz  = 24,
  parameter int p_sym_sz  = 2,
  parameter int p_dur_sz  = 16,
  parameter int p_pre_len = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [p_acc_sz-1:0] i_base_inc,
  input  logic [p_acc_sz-1:0] i_step_inc,
  input  logic [p_dur_sz-1:0] i_sym_dur,
  input  logic [p_sym_sz-1:0] i_sym,
  input  logic                i_sym_valid,
  output logic                o_sym_ready,
  output logic                o_fm,
  output logic [p_acc_sz-1:0] o_phase,
  output logic                o_busy,
  output logic                o_underrun,
  output logic [1:0]          o_state
);

`ifdef FSK_TX_PREAMBLE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PRE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  // Handshake: a symbol transfers on any cycle where i_sym_valid & o_sym_ready;
  // o_sym_ready depends only on registered state, never on i_sym_valid.

  state_t              state;
  logic [p_acc_sz-1:0] acc;
  logic [p_acc_sz-1:0] inc;
  logic [p_dur_sz-1:0] cnt;
  logic                ur;
  logic                accept;
  logic [p_dur_sz-1:0] dur_ld;
  logic [p_acc_sz-1:0] new_inc;

  function automatic logic [p_acc_sz-1:0] tone(input logic [p_acc_sz-1:0] b,
                                               input logic [p_acc_sz-1:0] s,
                                               input logic [p_sym_sz-1:0] k);
    return b + p_acc_sz'(k) * s;
  endfunction

  always_comb begin
    o_sym_ready = !i_rst && ((state == S_IDLE) || (state == S_RUN && cnt == '0));
    accept      = i_sym_valid && o_sym_ready;
    dur_ld      = (i_sym_dur == '0) ? '0 : i_sym_dur - p_dur_sz'(1);
    new_inc     = tone(i_base_inc, i_step_inc, i_sym);
  end

`ifdef FSK_TX_PREAMBLE_EN
  localparam int PW = (p_pre_len > 1) ? $clog2(p_pre_len) : 1;
  logic [p_sym_sz-1:0] sym_r;
  logic [p_acc_sz-1:0] base_r;
  logic [p_acc_sz-1:0] step_r;
  logic [p_dur_sz-1:0] dur_r;
  logic [PW-1:0]       pre_idx;
  logic [p_acc_sz-1:0] run_inc;
  logic [p_acc_sz-1:0] alt_inc;
  logic                pre_last;

  // alt_inc is the tone of the preamble symbol that follows pre_idx.
  always_comb begin
    run_inc  = tone(base_r, step_r, sym_r);
    alt_inc  = pre_idx[0] ? base_r : base_r + step_r;
    pre_last = (pre_idx == PW'(p_pre_len - 1));
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      acc   <= '0;
      inc   <= '0;
      cnt   <= '0;
      ur    <= 1'b0;
`ifdef FSK_TX_PREAMBLE_EN
      sym_r   <= '0;
      base_r  <= '0;
      step_r  <= '0;
      dur_r   <= '0;
      pre_idx <= '0;
`endif
    end else begin
      ur <= 1'b0;
      case (state)
        S_IDLE: begin
          acc <= '0;
          if (accept) begin
            cnt <= dur_ld;
`ifdef FSK_TX_PREAMBLE_EN
            sym_r   <= i_sym;
            base_r  <= i_base_inc;
            step_r  <= i_step_inc;
            dur_r   <= dur_ld;
            pre_idx <= '0;
            if (p_pre_len > 0) begin
              state <= S_PRE;
              inc   <= i_base_inc;
              acc   <= i_base_inc;
            end else begin
              state <= S_RUN;
              inc   <= new_inc;
              acc   <= new_inc;
            end
`else
            state <= S_RUN;
            inc   <= new_inc;
            acc   <= new_inc;
`endif
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            acc <= acc + inc;
            cnt <= cnt - p_dur_sz'(1);
          end else if (accept) begin
            // Zero-gap successor: phase carries straight on with the new tone.
            inc <= new_inc;
            acc <= acc + new_inc;
            cnt <= dur_ld;
          end else begin
            state <= S_IDLE;
            acc   <= '0;
            ur    <= 1'b1;
          end
        end
`ifdef FSK_TX_PREAMBLE_EN
        S_PRE: begin
          if (cnt != '0) begin
            acc <= acc + inc;
            cnt <= cnt - p_dur_sz'(1);
          end else if (pre_last) begin
            state <= S_RUN;
            inc   <= run_inc;
            acc   <= acc + run_inc;
            cnt   <= dur_r;
          end else begin
            pre_idx <= pre_idx + PW'(1);
            inc     <= alt_inc;
            acc     <= acc + alt_inc;
            cnt     <= dur_r;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          acc   <= '0;
        end
      endcase
    end
  end

  assign o_fm       = acc[p_acc_sz-1];
  assign o_phase    = acc;
  assign o_busy     = (state != S_IDLE);
  assign o_underrun = ur;
  assign o_state    = state;

endmodule
